// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order reorder buffer. Dispatch allocates entries at the tail
//   and receives the tail index as the ROB tag. The CDB and the load/store
//   buffer mark entries complete. The head entry retires at most once per
//   cycle. A retiring branch whose outcome differs from the prediction
//   raises a one-cycle flush and empties the buffer.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rdy                       global enable; low freezes all state and outputs
//   issue_*                   dispatch request; issue_tag/rob_full are combinational
//   cdb_*                     RS/ALU result broadcast (value, branch outcome)
//   lsb_*                     load/store completion
//   query_{j,k}_*             combinational operand lookup by tag
//   commit_*                  registered retire pulse and register-file write
//   flush, flush_pc           registered mispredict redirect pulse
//
// Handshake: issue_valid is a request and !rob_full is its ready; the issue
// is taken on a clk edge where rdy && issue_valid && !rob_full and no
// mispredict retires in the same cycle. cdb_valid/lsb_valid/commit_valid/
// flush are single-cycle strobes with no back-pressure.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred_taken,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_value,
  input  logic [TAG_W-1:0] query_j_tag,
  input  logic [TAG_W-1:0] query_k_tag,
  output logic             query_j_ready,
  output logic             query_k_ready,
  output logic [31:0]      query_j_value,
  output logic [31:0]      query_k_value,
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             commit_store,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam logic [1:0]     TYPE_STORE  = 2'd1;
  localparam logic [1:0]     TYPE_BRANCH = 2'd2;
  localparam logic [TAG_W:0] FULL_COUNT  = (TAG_W+1)'(ROB_SIZE);

  // Entry storage
  logic        busy_q   [ROB_SIZE];
  logic        ready_q  [ROB_SIZE];
  logic [1:0]  type_q   [ROB_SIZE];
  logic [4:0]  rd_q     [ROB_SIZE];
  logic [31:0] pc_q     [ROB_SIZE];
  logic        pred_q   [ROB_SIZE];
  logic [31:0] value_q  [ROB_SIZE];
  logic        taken_q  [ROB_SIZE];
  logic [31:0] target_q [ROB_SIZE];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q;

  logic        head_is_store, head_is_branch, head_is_reg;
  logic        commit_fire, flush_now, issue_accept;
  logic [31:0] redirect_pc;

  assign issue_tag      = tail_q;
  assign rob_full       = (count_q == FULL_COUNT);

  assign head_is_store  = (type_q[head_q] == TYPE_STORE);
  assign head_is_branch = (type_q[head_q] == TYPE_BRANCH);
  // Type 3 is an unused encoding and retires like a register writer.
  assign head_is_reg    = !head_is_store && !head_is_branch;

  // Ready is only observed from the stored bit, so a writeback landing at
  // edge N can retire no earlier than edge N+1.
  assign commit_fire  = rdy && busy_q[head_q] && ready_q[head_q];
  assign flush_now    = commit_fire && head_is_branch &&
                        (taken_q[head_q] != pred_q[head_q]);
  // rob_full uses the pre-edge count: a retire in the same cycle does not
  // free a slot for this cycle's issue.
  assign issue_accept = rdy && issue_valid && !rob_full && !flush_now;
  assign redirect_pc  = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;

  assign query_j_ready = busy_q[query_j_tag] && ready_q[query_j_tag];
  assign query_k_ready = busy_q[query_k_tag] && ready_q[query_k_tag];
  assign query_j_value = value_q[query_j_tag];
  assign query_k_value = value_q[query_k_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]   <= 1'b0;
        ready_q[i]  <= 1'b0;
        type_q[i]   <= '0;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        pred_q[i]   <= 1'b0;
        value_q[i]  <= '0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= '0;
      end
    end else if (rdy) begin
      // Retire pulses last exactly one enabled cycle.
      commit_valid <= commit_fire;
      commit_we    <= commit_fire && head_is_reg;
      commit_store <= commit_fire && head_is_store;
      flush        <= flush_now;
      if (commit_fire) begin
        commit_rd    <= rd_q[head_q];
        commit_value <= value_q[head_q];
        commit_tag   <= head_q;
      end
      if (flush_now) flush_pc <= redirect_pc;

      // LSB first so a CDB write to the same tag overrides it.
      if (lsb_valid && busy_q[lsb_tag]) begin
        ready_q[lsb_tag] <= 1'b1;
        if (type_q[lsb_tag] != TYPE_STORE) value_q[lsb_tag] <= lsb_value;
      end
      if (cdb_valid && busy_q[cdb_tag]) begin
        ready_q[cdb_tag]  <= 1'b1;
        value_q[cdb_tag]  <= cdb_value;
        taken_q[cdb_tag]  <= cdb_taken;
        target_q[cdb_tag] <= cdb_target;
      end

      if (issue_accept) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        type_q[tail_q]  <= issue_type;
        rd_q[tail_q]    <= issue_rd;
        pc_q[tail_q]    <= issue_pc;
        pred_q[tail_q]  <= issue_pred_taken;
        tail_q          <= tail_q + TAG_W'(1);
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + TAG_W'(1);
      end
      unique case ({issue_accept, commit_fire})
        2'b10:   count_q <= count_q + (TAG_W+1)'(1);
        2'b01:   count_q <= count_q - (TAG_W+1)'(1);
        default: count_q <= count_q;
      endcase

      // A mispredict discards every younger entry; it overrides the
      // pointer and count updates above.
      if (flush_now) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < ROB_SIZE; i++) busy_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic,
// checked against a queue-of-instructions reference model.
module tb_reorder_buffer;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred_taken;
  logic [3:0]  issue_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_taken;
  logic [31:0] cdb_target;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_value;
  logic [3:0]  query_j_tag, query_k_tag;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        commit_valid, commit_we, commit_store, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;
  logic [3:0]  commit_tag;

  reorder_buffer #(.ROB_SIZE(N), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_tag(issue_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
    .query_j_tag(query_j_tag), .query_k_tag(query_k_tag),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  tag;
    logic        we;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        fl;
    logic [31:0] fpc;
  } cmt_t;
  localparam int EXP_W = $bits(cmt_t);
  logic [EXP_W-1:0] exp_q[$];

  // Outstanding instructions, oldest first.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] val;
    logic        taken;
    logic [31:0] tgt;
    bit          done;
  } ent_t;
  ent_t rob_m[$];
  int   m_tail = 0;

  function automatic int find_idx(logic [3:0] t);
    for (int i = 0; i < rob_m.size(); i++)
      if (rob_m[i].tag == t) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    rob_m.delete();
    exp_q.delete();
    m_tail = 0;
  endfunction

  function automatic void check_query(string nm, logic [3:0] t, logic r, logic [31:0] v);
    int  qi;
    bit  er;
    qi = find_idx(t);
    er = (qi >= 0) ? rob_m[qi].done : 1'b0;
    chk({nm, "_ready"}, 32'(r), 32'(er));
    if (er && rob_m[qi].ty != 2'd1) chk({nm, "_value"}, v, rob_m[qi].val);
  endfunction

  // Checks the combinational outputs against the model, then predicts what
  // the coming clock edge does with the current inputs.
  task automatic model_step();
    cmt_t rec;
    ent_t e;
    bit   commit, misp, acc;
    int   li, ci;
    chk("issue_tag", 32'(issue_tag), 32'(m_tail));
    chk("rob_full", 32'(rob_full), 32'(rob_m.size() == N));
    check_query("query_j", query_j_tag, query_j_ready, query_j_value);
    check_query("query_k", query_k_tag, query_k_ready, query_k_value);
    if (!rdy) return;
    commit = (rob_m.size() > 0) && rob_m[0].done;
    misp   = commit && rob_m[0].ty == 2'd2 && rob_m[0].taken != rob_m[0].pred;
    acc    = issue_valid && rob_m.size() < N && !misp;
    if (commit) begin
      e       = rob_m[0];
      rec.tag = e.tag;
      rec.we  = (e.ty == 2'd0) || (e.ty == 2'd3);
      rec.st  = (e.ty == 2'd1);
      rec.rd  = e.rd;
      rec.val = e.val;
      rec.fl  = misp;
      rec.fpc = e.taken ? e.tgt : e.pc + 32'd4;
      exp_q.push_back(rec);
    end
    if (lsb_valid) begin
      li = find_idx(lsb_tag);
      if (li >= 0) begin
        e = rob_m[li];
        if (e.ty != 2'd1) e.val = lsb_value;
        e.done = 1'b1;
        rob_m[li] = e;
      end
    end
    if (cdb_valid) begin
      ci = find_idx(cdb_tag);
      if (ci >= 0) begin
        e = rob_m[ci];
        e.val   = cdb_value;
        e.taken = cdb_taken;
        e.tgt   = cdb_target;
        e.done  = 1'b1;
        rob_m[ci] = e;
      end
    end
    if (misp) begin
      rob_m.delete();
      m_tail = 0;
    end else begin
      if (commit) void'(rob_m.pop_front());
      if (acc) begin
        e.tag   = 4'(m_tail);
        e.ty    = issue_type;
        e.rd    = issue_rd;
        e.pc    = issue_pc;
        e.pred  = issue_pred_taken;
        e.val   = '0;
        e.taken = 1'b0;
        e.tgt   = '0;
        e.done  = 1'b0;
        rob_m.push_back(e);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic r;
    cmt_t e;
    forever begin
      @(posedge clk);
      r = rdy;
      #2;
      if (!rst && r) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("commit_valid", 32'(commit_valid), 32'd1);
          if (commit_valid) begin
            chk("commit_tag", 32'(commit_tag), 32'(e.tag));
            chk("commit_we", 32'(commit_we), 32'(e.we));
            chk("commit_store", 32'(commit_store), 32'(e.st));
            chk("flush", 32'(flush), 32'(e.fl));
            if (e.we) begin
              chk("commit_rd", 32'(commit_rd), 32'(e.rd));
              chk("commit_value", commit_value, e.val);
            end
            if (e.fl) chk("flush_pc", flush_pc, e.fpc);
          end
        end else begin
          chk("commit_idle", 32'(commit_valid), 32'd0);
          chk("flush_idle", 32'(flush), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    lsb_valid   = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] ty, input logic [4:0] rd,
                           input logic [31:0] pc, input logic pred);
    issue_valid = 1'b1; issue_type = ty; issue_rd = rd;
    issue_pc = pc; issue_pred_taken = pred;
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] v,
                         input logic tk, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk; cdb_target = tgt;
  endtask

  task automatic set_lsb(input logic [3:0] t, input logic [31:0] v);
    lsb_valid = 1'b1; lsb_tag = t; lsb_value = v;
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    clear_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Completes every outstanding entry and lets the buffer empty.
  task automatic drain();
    int open[$];
    int i;
    rdy = 1'b1;
    for (int n = 0; n < 200 && rob_m.size() > 0; n++) begin
      open.delete();
      for (int k = 0; k < rob_m.size(); k++) if (!rob_m[k].done) open.push_back(k);
      if (open.size() > 0) begin
        i = open[$urandom_range(0, open.size() - 1)];
        set_cdb(rob_m[i].tag, $urandom, rob_m[i].pred, $urandom);
      end
      tick();
    end
    chk("drain_empty", 32'(rob_m.size()), 32'd0);
  endtask

  task automatic rand_cycle();
    int open[$];
    int i;
    rdy = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 9) < 6)
      set_issue(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)));
    for (int k = 0; k < rob_m.size(); k++) if (!rob_m[k].done) open.push_back(k);
    if (open.size() > 0 && $urandom_range(0, 2) != 0) begin
      i = open[$urandom_range(0, open.size() - 1)];
      set_cdb(rob_m[i].tag, $urandom,
              ($urandom_range(0, 4) == 0) ? ~rob_m[i].pred : rob_m[i].pred, $urandom);
    end else if ($urandom_range(0, 9) == 0) begin
      set_cdb(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), $urandom);
    end
    if (open.size() > 0 && $urandom_range(0, 2) == 0) begin
      i = open[$urandom_range(0, open.size() - 1)];
      if (rob_m[i].ty != 2'd2) set_lsb(rob_m[i].tag, $urandom);
    end
    query_j_tag = 4'($urandom_range(0, 15));
    query_k_tag = 4'($urandom_range(0, 15));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [3:0] t;
    rst = 1'b1; rdy = 1'b1;
    issue_type = '0; issue_rd = '0; issue_pc = '0; issue_pred_taken = 1'b0;
    cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    lsb_tag = '0; lsb_value = '0; query_j_tag = '0; query_k_tag = '0;
    clear_in();
    do_reset();

    // Reset state of registered outputs
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_we", 32'(commit_we), 32'd0);
    chk("rst_commit_store", 32'(commit_store), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    chk("rst_commit_tag", 32'(commit_tag), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);

    // Single REG instruction, then a held pulse under rdy low
    set_issue(2'd0, 5'd5, 32'h40, 1'b0); tick();
    set_cdb(4'd0, 32'h1234, 1'b0, 32'h0); tick();
    tick();
    rdy = 1'b0; tick();
    chk("hold_commit_valid", 32'(commit_valid), 32'd1);
    chk("hold_commit_value", commit_value, 32'h1234);
    rdy = 1'b1; tick(); tick();

    // Fill, reject the 17th, retire one, then wrap the tail
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_issue(2'd0, 5'(i + 1), 32'(32'h1000 + 4 * i), 1'b0); tick();
    end
    set_issue(2'd0, 5'd31, 32'h2000, 1'b0); tick();
    set_cdb(4'd0, 32'hAB, 1'b0, 32'h0); tick();
    set_issue(2'd0, 5'd30, 32'h2004, 1'b0); tick();  // rejected: pre-edge full
    set_issue(2'd0, 5'd29, 32'h2008, 1'b0); tick();  // lands at tag 0
    drain();

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(2'd0, 5'(10 + i), 32'(32'h300 + 4 * i), 1'b0); tick();
    end
    set_cdb(4'd2, 32'h22, 1'b0, 32'h0); tick();
    set_cdb(4'd1, 32'h11, 1'b0, 32'h0); tick();
    set_cdb(4'd0, 32'h00, 1'b0, 32'h0); tick();
    repeat (4) tick();

    // Mispredicted branch with a younger REG and a dropped issue
    do_reset();
    set_issue(2'd2, 5'd0, 32'h100, 1'b0); tick();
    set_issue(2'd0, 5'd7, 32'h104, 1'b0); tick();
    set_cdb(4'd0, 32'h0, 1'b1, 32'h200); tick();
    set_issue(2'd0, 5'd9, 32'h108, 1'b0); tick();
    query_j_tag = 4'd1; tick();
    repeat (2) tick();

    // Predicted-taken branch falls through at the top of memory
    do_reset();
    set_issue(2'd2, 5'd0, 32'hFFFF_FFFC, 1'b1); tick();
    set_cdb(4'd0, 32'h0, 1'b0, 32'h1234); tick();
    repeat (3) tick();
    // Correctly predicted branch: no flush
    t = 4'(m_tail);
    set_issue(2'd2, 5'd0, 32'h300, 1'b1); tick();
    set_cdb(t, 32'h0, 1'b1, 32'h400); tick();
    repeat (2) tick();

    // STORE retire, then simultaneous CDB+LSB on one REG tag
    do_reset();
    set_issue(2'd1, 5'd3, 32'h500, 1'b0); tick();
    set_lsb(4'd0, 32'hDEAD); tick();
    tick();
    t = 4'(m_tail);
    set_issue(2'd0, 5'd12, 32'h504, 1'b0); tick();
    set_cdb(t, 32'hAAAA_0001, 1'b0, 32'h0);
    set_lsb(t, 32'hBBBB_0002); tick();
    repeat (2) tick();

    // Asynchronous reset with a retire pending
    do_reset();
    set_issue(2'd0, 5'd3, 32'h600, 1'b0); tick();
    set_issue(2'd0, 5'd4, 32'h604, 1'b0); tick();
    set_cdb(4'd0, 32'h77, 1'b0, 32'h0); tick();
    set_cdb(4'd1, 32'h88, 1'b0, 32'h0); tick();
    query_j_tag = 4'd1;
    #2 rst = 1'b1;
    #1;
    chk("arst_commit_valid", 32'(commit_valid), 32'd0);
    chk("arst_commit_we", 32'(commit_we), 32'd0);
    chk("arst_commit_rd", 32'(commit_rd), 32'd0);
    chk("arst_commit_value", commit_value, 32'd0);
    chk("arst_query_ready", 32'(query_j_ready), 32'd0);
    chk("arst_issue_tag", 32'(issue_tag), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) rand_cycle();
    drain();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
